align_shift_pipe: RTL



---
 rtl/fp_shift_pkg.sv | 12 +
 rtl/align_shift_stage.sv | 63 ++++++
 rtl/align_shift_pipe.sv | 98 +++++++++
 3 files changed

// File: rtl/fp_shift_pkg.sv
// Shared types and defaults for the alignment shifter.
package fp_shift_pkg;
  typedef enum logic {SHIFT_LOGICAL = 1'b0, SHIFT_ARITH = 1'b1} shift_mode_e;

  localparam int DEF_WIDTH  = 24;
  localparam int DEF_STAGES = 5;
  localparam int DEF_SA_W   = 8;

  function automatic logic fill_bit(shift_mode_e mode, logic msb);
    return (mode == SHIFT_ARITH) & msb;
  endfunction
endpackage

// File: rtl/align_shift_stage.sv
// One 2^K right-shift step with guard/round/sticky update, followed by an elastic slot.
module align_shift_stage
  import fp_shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int TAG_W  = 4,
  parameter int K      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH+1:0]    in_dp,
  input  logic                in_sticky,
  input  logic                in_fill,
  input  logic [STAGES-1:0]   in_shamt,
  input  logic                in_flush,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH+1:0]    out_dp,
  output logic                out_sticky,
  output logic                out_fill,
  output logic [STAGES-1:0]   out_shamt,
  output logic                out_flush,
  output logic [TAG_W-1:0]    out_tag
);
  localparam int DW = WIDTH + 2;
  localparam int SH = 1 << K;

  logic              vld_q;
  logic              take;
  logic [DW+SH-1:0]  hi_ext, lo_ext;
  logic [DW-1:0]     dp_nxt;
  logic              sticky_nxt;

  // Flushed beats were fully formed at the input; they just ride through.
  assign take       = in_shamt[K] & ~in_flush;
  assign hi_ext     = {{SH{in_fill}}, in_dp};
  assign lo_ext     = {{SH{1'b0}}, in_dp};
  assign dp_nxt     = take ? hi_ext[DW+SH-1:SH] : in_dp;
  assign sticky_nxt = in_sticky | (take & (|lo_ext[SH-1:0]));

  assign in_ready  = ~vld_q | out_ready;
  assign out_valid = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vld_q <= 1'b0;
    else if (in_ready) vld_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      out_dp     <= dp_nxt;
      out_sticky <= sticky_nxt;
      out_fill   <= in_fill;
      out_shamt  <= in_shamt;
      out_flush  <= in_flush;
      out_tag    <= in_tag;
    end
  end
endmodule

// File: rtl/align_shift_pipe.sv
// Pipelined right-shift aligner: STAGES barrel steps, valid/ready handshake, G/R/S output.
module align_shift_pipe
  import fp_shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int SA_W   = DEF_SA_W,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SA_W-1:0]   in_shamt,
  input  logic              in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_guard,
  output logic              out_round,
  output logic              out_sticky,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int DW = WIDTH + 2;

  logic [STAGES:0]              vld_pipe, sticky_p, fill_p, flush_p;
  logic [STAGES:0][DW-1:0]      dp_p;
  logic [STAGES:0][STAGES-1:0]  sa_p;
  logic [STAGES:0][TAG_W-1:0]   tag_p;
  logic [STAGES-1:0]            dn_rdy, up_rdy;
  logic                         flush_in, fill_in;
  logic                         unused_sink;

  generate
    if (SA_W > STAGES) begin : g_flush
      assign flush_in = |in_shamt[SA_W-1:STAGES];
    end else begin : g_noflush
      assign flush_in = 1'b0;
    end
  endgenerate

  assign fill_in     = fill_bit(shift_mode_e'(in_mode), in_data[WIDTH-1]);
  assign vld_pipe[0] = in_valid;
  assign dp_p[0]     = flush_in ? {DW{fill_in}} : {in_data, 2'b00};
  assign sticky_p[0] = flush_in & (|in_data);
  assign fill_p[0]   = fill_in;
  assign flush_p[0]  = flush_in;
  assign sa_p[0]     = in_shamt[STAGES-1:0];
  assign tag_p[0]    = in_tag;

  // Slot i may advance iff out_ready or some later slot has a hole; flattening the
  // ready chain this way keeps it free of any self-referencing combinational vector.
  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      if (i == STAGES - 1) begin : g_last
        assign dn_rdy[i] = out_ready;
      end else begin : g_mid
        assign dn_rdy[i] = out_ready | ~(&vld_pipe[STAGES:i+2]);
      end

      align_shift_stage #(
        .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .K(STAGES - 1 - i)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld_pipe[i]),
        .in_ready  (up_rdy[i]),
        .in_dp     (dp_p[i]),
        .in_sticky (sticky_p[i]),
        .in_fill   (fill_p[i]),
        .in_shamt  (sa_p[i]),
        .in_flush  (flush_p[i]),
        .in_tag    (tag_p[i]),
        .out_valid (vld_pipe[i+1]),
        .out_ready (dn_rdy[i]),
        .out_dp    (dp_p[i+1]),
        .out_sticky(sticky_p[i+1]),
        .out_fill  (fill_p[i+1]),
        .out_shamt (sa_p[i+1]),
        .out_flush (flush_p[i+1]),
        .out_tag   (tag_p[i+1])
      );
    end
  endgenerate

  assign in_ready   = rst_n & up_rdy[0];
  assign out_valid  = vld_pipe[STAGES];
  assign out_data   = dp_p[STAGES][DW-1:2];
  assign out_guard  = dp_p[STAGES][1];
  assign out_round  = dp_p[STAGES][0];
  assign out_sticky = sticky_p[STAGES];
  assign out_tag    = tag_p[STAGES];

  assign unused_sink = ^{up_rdy, fill_p[STAGES], flush_p[STAGES], sa_p[STAGES]};
endmodule
